// File: rtl/tusca_pkg.sv
// Shared definitions for the TUSCA sensing-loop control unit: state codes and width helper.
package tusca_pkg;

  localparam int unsigned ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    StInicial      = 3'd0,
    StMede         = 3'd1,
    StEsperaMedida = 3'd2,
    StProximo      = 3'd3,
    StResetaDelay  = 3'd4,
    StEsperaDelay  = 3'd5,
    StEsperaConfig = 3'd6
  } estado_t;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned largura(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tusca_contador.sv
// Saturating up-counter with synchronous clear; fim flags the terminal count MODULO-1.
module tusca_contador
  import tusca_pkg::*;
#(
  parameter int unsigned MODULO = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = largura(MODULO);
  localparam logic [W-1:0] MAXIMO = W'(MODULO - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta && (cnt_q != MAXIMO)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim = (cnt_q == MAXIMO);

endmodule

// File: rtl/tusca_uc_multi.sv
// Round-robin measurement sequencer with inter-sweep delay and configuration window.
// Optional per-channel timeout detection is enabled by defining TUSCA_UC_TIMEOUT_EN.
module tusca_uc_multi
  import tusca_pkg::*;
#(
  parameter int unsigned N_SENSORES     = 2,
  parameter int unsigned DELAY_CICLOS   = 50000000,
  parameter int unsigned TIMEOUT_CICLOS = 1000000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_SENSORES-1:0]               pronto_medida,
  input  logic                                definir_config,
  input  logic                                pronto_config,
  output logic [N_SENSORES-1:0]               medir,
  output logic [largura(N_SENSORES)-1:0]      canal,
  output logic                                receber_config,
  output logic                                ciclo_completo,
  output logic [N_SENSORES-1:0]               erro_timeout,
  output logic [ESTADO_W-1:0]                 estado
);

  localparam int unsigned CANAL_W = largura(N_SENSORES);
  localparam logic [CANAL_W-1:0] ULTIMO = CANAL_W'(N_SENSORES - 1);

  estado_t              state_q, state_d;
  logic [CANAL_W-1:0]   canal_q, canal_d;
  logic                 ultimo, pronto_sel;
  logic                 d_zera, d_conta, d_fim;

  assign ultimo     = (canal_q == ULTIMO);
  assign pronto_sel = pronto_medida[canal_q];

  tusca_contador #(
    .MODULO (DELAY_CICLOS)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .zera  (d_zera),
    .conta (d_conta),
    .fim   (d_fim)
  );

`ifdef TUSCA_UC_TIMEOUT_EN
  logic                  t_zera, t_conta, t_fim;
  logic [N_SENSORES-1:0] erro_q, erro_d;

  tusca_contador #(
    .MODULO (TIMEOUT_CICLOS)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (t_zera),
    .conta (t_conta),
    .fim   (t_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      erro_q <= '0;
    end else begin
      erro_q <= erro_d;
    end
  end

  assign erro_timeout = erro_q;
`else
  logic unused_cfg;
  assign unused_cfg   = (TIMEOUT_CICLOS > 0);
  assign erro_timeout = '0;
`endif

  always_comb begin
    state_d        = state_q;
    canal_d        = canal_q;
    medir          = '0;
    receber_config = 1'b0;
    ciclo_completo = 1'b0;
    d_zera         = 1'b0;
    d_conta        = 1'b0;
`ifdef TUSCA_UC_TIMEOUT_EN
    erro_d         = erro_q;
    t_zera         = 1'b0;
    t_conta        = 1'b0;
`endif
    case (state_q)
      StInicial: state_d = StMede;
      StMede: begin
        medir[canal_q] = 1'b1;
`ifdef TUSCA_UC_TIMEOUT_EN
        t_zera         = 1'b1;
`endif
        state_d        = StEsperaMedida;
      end
      StEsperaMedida: begin
`ifdef TUSCA_UC_TIMEOUT_EN
        t_conta = 1'b1;
        // A late answer on the terminal cycle still counts as a good measurement.
        if (pronto_sel) begin
          erro_d[canal_q] = 1'b0;
          state_d         = StProximo;
        end else if (t_fim) begin
          erro_d[canal_q] = 1'b1;
          state_d         = StProximo;
        end
`else
        if (pronto_sel) begin
          state_d = StProximo;
        end
`endif
      end
      StProximo: begin
        if (ultimo) begin
          canal_d        = '0;
          ciclo_completo = 1'b1;
          state_d        = StResetaDelay;
        end else begin
          canal_d = canal_q + 1'b1;
          state_d = StMede;
        end
      end
      StResetaDelay: begin
        d_zera  = 1'b1;
        state_d = StEsperaDelay;
      end
      StEsperaDelay: begin
        d_conta = 1'b1;
        if (d_fim) begin
          state_d = StMede;
        end else if (definir_config) begin
          state_d = StEsperaConfig;
        end
      end
      StEsperaConfig: begin
        receber_config = 1'b1;
        if (pronto_config) begin
          state_d = StResetaDelay;
        end
      end
      default: state_d = StInicial;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StInicial;
      canal_q <= '0;
    end else begin
      state_q <= state_d;
      canal_q <= canal_d;
    end
  end

  assign canal  = canal_q;
  assign estado = state_q;

endmodule

// File: tb/tb_tusca_uc_multi.sv
// Directed bench for tusca_uc_multi (N_SENSORES=3, DELAY_CICLOS=10, TIMEOUT_CICLOS=8).
module tb_tusca_uc_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] pronto_medida;
  logic       definir_config;
  logic       pronto_config;
  logic [2:0] medir;
  logic [1:0] canal;
  logic       receber_config;
  logic       ciclo_completo;
  logic [2:0] erro_timeout;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

`ifdef TUSCA_UC_TIMEOUT_EN
  localparam logic [2:0] ERRO_CANAL1 = 3'b010;
`else
  localparam logic [2:0] ERRO_CANAL1 = 3'b000;
`endif

  always #5 clock = ~clock;

  tusca_uc_multi #(
    .N_SENSORES     (3),
    .DELAY_CICLOS   (10),
    .TIMEOUT_CICLOS (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pronto_medida  (pronto_medida),
    .definir_config (definir_config),
    .pronto_config  (pronto_config),
    .medir          (medir),
    .canal          (canal),
    .receber_config (receber_config),
    .ciclo_completo (ciclo_completo),
    .erro_timeout   (erro_timeout),
    .estado         (estado)
  );

  typedef struct {
    logic [2:0] pm;
    logic       dc;
    logic       pc;
    logic [2:0] e_estado;
    logic [2:0] e_medir;
    logic [1:0] e_canal;
    logic       e_rc;
    logic       e_cc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] pm, input logic dc, input logic pc, input logic [2:0] st,
                     input logic [2:0] md, input logic [1:0] c, input logic rc, input logic cc);
    vec_t v;
    v.pm = pm; v.dc = dc; v.pc = pc;
    v.e_estado = st; v.e_medir = md; v.e_canal = c; v.e_rc = rc; v.e_cc = cc;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Entered at the MEDE sample of channel c; answers at once; leaves at the following sample.
  task automatic chan_ok(input int c);
    check("chan_medir", medir, 32'(1 << c));
    check("chan_canal", canal, c);
    check("chan_estado_mede", estado, 1);
    tick();
    check("chan_estado_espera", estado, 2);
    pronto_medida = 3'(1 << c);
    tick();
    pronto_medida = '0;
    check("chan_estado_proximo", estado, 3);
    check("chan_ciclo", ciclo_completo, (c == 2) ? 1 : 0);
    tick();
  endtask

  // Entered at the RESETA_DELAY sample; leaves at the MEDE sample of channel 0.
  task automatic delay_phase();
    check("delay_reseta", estado, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("delay_espera", estado, 5);
    end
    tick();
    check("delay_fim_estado", estado, 1);
    check("delay_fim_canal", canal, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_estado"}, estado, 0);
    check({tag, "_medir"}, medir, 0);
    check({tag, "_canal"}, canal, 0);
    check({tag, "_receber"}, receber_config, 0);
    check({tag, "_ciclo"}, ciclo_completo, 0);
    check({tag, "_erro"}, erro_timeout, 0);
  endtask

  initial begin
    reset          = 1'b1;
    pronto_medida  = '0;
    definir_config = 1'b0;
    pronto_config  = 1'b0;

    // Normal sweep; stray definir_config/pronto_config outside the delay are ignored.
    add(3'b000, 0, 0, 3'd0, 3'b000, 2'd0, 0, 0);
    add(3'b000, 1, 0, 3'd1, 3'b001, 2'd0, 0, 0);
    add(3'b001, 0, 1, 3'd2, 3'b000, 2'd0, 0, 0);
    add(3'b000, 0, 0, 3'd3, 3'b000, 2'd0, 0, 0);
    add(3'b000, 0, 0, 3'd1, 3'b010, 2'd1, 0, 0);
    add(3'b010, 0, 0, 3'd2, 3'b000, 2'd1, 0, 0);
    add(3'b000, 1, 0, 3'd3, 3'b000, 2'd1, 0, 0);
    add(3'b000, 0, 0, 3'd1, 3'b100, 2'd2, 0, 0);
    add(3'b100, 0, 0, 3'd2, 3'b000, 2'd2, 0, 0);
    add(3'b000, 0, 0, 3'd3, 3'b000, 2'd2, 0, 1);
    add(3'b000, 0, 0, 3'd4, 3'b000, 2'd0, 0, 0);
    for (int i = 0; i < 10; i++) add(3'b000, 0, 0, 3'd5, 3'b000, 2'd0, 0, 0);

    tick();
    tick();
    check_reset_outputs("reset_init");
    reset = 1'b0;

    foreach (vecs[i]) begin
      check("vec_estado", estado, vecs[i].e_estado);
      check("vec_medir", medir, vecs[i].e_medir);
      check("vec_canal", canal, vecs[i].e_canal);
      check("vec_receber", receber_config, vecs[i].e_rc);
      check("vec_ciclo", ciclo_completo, vecs[i].e_cc);
      check("vec_erro", erro_timeout, 0);
      pronto_medida  = vecs[i].pm;
      definir_config = vecs[i].dc;
      pronto_config  = vecs[i].pc;
      tick();
    end
    pronto_medida  = '0;
    definir_config = 1'b0;
    pronto_config  = 1'b0;
    check("sweep2_start", medir, 3'b001);

    // Channel 1 silent.
    chan_ok(0);
    check("t2_medir1", medir, 3'b010);
    tick();
`ifdef TUSCA_UC_TIMEOUT_EN
    repeat (7) tick();
    check("t2_still_waiting", estado, 2);
    check("t2_no_flag_yet", erro_timeout, 0);
    tick();
    check("t2_timeout_estado", estado, 3);
    check("t2_timeout_flag", erro_timeout, 3'b010);
`else
    repeat (20) tick();
    check("t2_waits_forever", estado, 2);
    check("t2_no_flag", erro_timeout, 0);
    pronto_medida = 3'b010;
    tick();
    pronto_medida = '0;
    check("t2_late_answer", estado, 3);
`endif
    tick();
    chan_ok(2);
    delay_phase();
    check("t2_flag_sticky", erro_timeout, ERRO_CANAL1);
    chan_ok(0);
    chan_ok(1);
    check("t2_flag_cleared", erro_timeout, 0);

    // Only the current channel's pronto bit matters.
    chan_ok(2);
    delay_phase();
    tick();
    pronto_medida = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_ignore_other_bit", estado, 2);
    end
    pronto_medida = 3'b001;
    tick();
    pronto_medida = '0;
    check("t3_own_bit", estado, 3);
    tick();
    chan_ok(1);
    chan_ok(2);

    // Configuration request at delay count 4, long configuration, delay restarts.
    check("t4_reseta", estado, 4);
    tick();
    repeat (4) tick();
    check("t4_espera_delay", estado, 5);
    definir_config = 1'b1;
    tick();
    definir_config = 1'b0;
    check("t4_config_estado", estado, 6);
    check("t4_receber", receber_config, 1);
    repeat (20) tick();
    check("t4_config_hold", estado, 6);
    check("t4_receber_hold", receber_config, 1);
    pronto_config = 1'b1;
    tick();
    pronto_config = 1'b0;
    check("t4_receber_off", receber_config, 0);
    delay_phase();

    // definir_config coinciding with the terminal delay count loses.
    chan_ok(0);
    chan_ok(1);
    chan_ok(2);
    tick();
    repeat (9) tick();
    check("t5_last_delay", estado, 5);
    definir_config = 1'b1;
    tick();
    definir_config = 1'b0;
    check("t5_fim_wins", estado, 1);
    check("t5_receber", receber_config, 0);
    check("t5_medir", medir, 3'b001);

    // Asynchronous reset in ESPERA_MEDIDA.
    tick();
    check("t6_in_espera", estado, 2);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6_rst_medida");
    tick();
    reset = 1'b0;
    tick();
    check("t6_resume_medir", medir, 3'b001);
    chan_ok(0);
    chan_ok(1);
    chan_ok(2);

    // Asynchronous reset in ESPERA_CONFIG.
    tick();
    tick();
    definir_config = 1'b1;
    tick();
    definir_config = 1'b0;
    check("t6_in_config", estado, 6);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6_rst_config");
    tick();
    reset = 1'b0;
    check("t6_released", estado, 0);
    tick();
    chan_ok(0);
    chan_ok(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
